regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the single write port (we3/wa3/wd3) of the 32x64 register file between two writeback sources. Source A is the in-order pipeline WB stage: high priority, no backpressure. Source B is a multi-cycle unit (divider/long-latency load): valid/ready handshake, buffered in a small FIFO. A starvation counter forces a one-cycle pipeline stall so B always drains. Sits between the WB stage, the multi-cycle unit and the regfile write port.

Parameters:
DEPTH, 4, B-side FIFO entries; power of 2, at least 2
MAX_STARVE, 8, consecutive cycles a non-empty FIFO may go ungranted before stall_o is raised
DW, 64, data width

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-high; clears FIFO and counter
a_valid  in  1  pipeline WB write request
a_addr  in  5  pipeline destination register
a_data  in  DW  pipeline write data
b_valid  in  1  multi-cycle unit result valid
b_ready  out  1  FIFO can accept (not full)
b_addr  in  5  multi-cycle destination register
b_data  in  DW  multi-cycle result
stall_o  out  1  pipeline must hold WB this cycle; A request ignored and re-presented
we3  out  1  to regfile
wa3  out  5  to regfile
wd3  out  DW  to regfile
fifo_count  out  log2(DEPTH)+1  occupancy, for debug/perf

Behaviour:
- Reset (async): FIFO empty, rd/wr pointers 0, starve counter 0. Outputs: b_ready=1, stall_o=0, we3=0, wa3=0, wd3=0, fifo_count=0.
- B accept: handshake on b_valid & b_ready at posedge pushes {b_addr,b_data}. A B request with b_addr==31 is accepted (handshake completes) but never pushed.
- Grant, combinational on the current cycle:
  - stall_o=1 -> grant FIFO head.
  - else a_valid -> grant A.
  - else FIFO non-empty -> grant head.
  - else idle: we3=0, wa3=0, wd3=0.
  - Granted path drives we3=1, wa3, wd3 with zero latency; a granted head pops at posedge.
- A writes to 31 still use the port (the regfile discards them) and count as grants.
- stall_o = (starve_cnt == MAX_STARVE) & FIFO non-empty. The counter:
  - increments each cycle the FIFO is non-empty and not granted;
  - clears on any pop or when the FIFO is empty;
  - saturates at MAX_STARVE.
- Simultaneous push and pop while full: push is refused, because b_ready is computed from the current count only (no same-cycle pass-through).
- Push and pop on a non-full FIFO in the same cycle: count unchanged.
- Pointers wrap modulo DEPTH. fifo_count is exact from 0 to DEPTH.
- Write ordering between A and B to the same register is not resolved here; the issue logic/scoreboard guarantees it (see optional feature).
- Reset mid-operation: FIFO contents are discarded and no write is emitted after reset asserts.

Optional Feature:
WB_ARB_HAZARD_EN
- Defined: adds inputs ra1, ra2 (5b each) from decode and output hazard_o. hazard_o=1 when any valid FIFO entry's address equals ra1 or ra2, with address 31 excluded. It is combinational, for the hazard unit to stall decode.
- Not defined: ports absent, no comparators synthesized.

Decomposition:
- Shared package (regfile_pkg): REG_ZR=5'd31; typedef wb_req_t {logic [4:0] addr; logic [63:0] data;}; NUM_REGS=32.
- One natural sub-module: wb_fifo, a parameterized sync FIFO with push/pop/full/empty/count and, under the macro, per-entry address visibility. The arbiter top holds grant muxing and the starvation counter.

Test Plan:
- Reset then idle -> we3=0, wa3=0, wd3=0, b_ready=1, fifo_count=0. Assert reset mid-fill (count 3) -> count=0 immediately, we3=0.
- a_valid, a_addr=5, a_data=0xAA, FIFO empty -> same cycle we3=1, wa3=5, wd3=0xAA.
- Push B addr 7 data 0x77 while a_valid=0 -> next cycle we3=1, wa3=7, wd3=0x77; count returns to 0 after that posedge.
- Push 1 B entry, then hold a_valid=1 continuously -> stall_o=1 in the cycle after 8 ungranted cycles; that cycle wa3=B addr; counter clears; A granted again next cycle.
- Push 4 entries with a_valid=1 throughout and no starvation -> b_ready=0 at count 4. A 5th b_valid is not accepted until a pop occurs.
- b_addr=31 handshake -> accepted, count unchanged, no write emitted.
- With WB_ARB_HAZARD_EN: FIFO holds addr 9, ra1=9 -> hazard_o=1. ra1=31 with an entry at 31 impossible -> hazard_o=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared regfile definitions used by the writeback arbiter and its B-side FIFO.
package regfile_pkg;
  localparam int NUM_REGS = 32;
  localparam logic [4:0] REG_ZR = 5'd31;

  typedef struct packed {
    logic [4:0]  addr;
    logic [63:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for B-side writeback requests; with WB_ARB_HAZARD_EN it also
// exposes every entry's address and occupancy bit for hazard comparison.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [4:0]               push_addr,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
`ifdef WB_ARB_HAZARD_EN
  output logic [DEPTH-1:0][4:0]    entry_addr,
  output logic [DEPTH-1:0]         entry_valid,
`endif
  output logic [4:0]               head_addr,
  output logic [DW-1:0]            head_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign count   = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage has no reset; occupancy comes only from the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

`ifdef WB_ARB_HAZARD_EN
  // An entry is live when its distance from the read pointer is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [AW-1:0] offset;
    assign offset         = AW'(i) - rd_ptr;
    assign entry_addr[i]  = addr_mem[i];
    assign entry_valid[i] = ({1'b0, offset} < count_q);
  end
`endif
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the regfile write port between the pipeline WB stage and a buffered
// multi-cycle unit, with a starvation stall. Optional macro: WB_ARB_HAZARD_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int MAX_STARVE = 8,
  parameter int DW         = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_valid,
  input  logic [4:0]               a_addr,
  input  logic [DW-1:0]            a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [4:0]               b_addr,
  input  logic [DW-1:0]            b_data,
  output logic                     stall_o,
`ifdef WB_ARB_HAZARD_EN
  input  logic [4:0]               ra1,
  input  logic [4:0]               ra2,
  output logic                     hazard_o,
`endif
  output logic                     we3,
  output logic [4:0]               wa3,
  output logic [DW-1:0]            wd3,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int SW = $clog2(MAX_STARVE + 1);

  logic          full, empty, push, pop;
  logic [4:0]    head_addr;
  logic [DW-1:0] head_data;
  logic [SW-1:0] starve_cnt;
`ifdef WB_ARB_HAZARD_EN
  logic [DEPTH-1:0][4:0] entry_addr;
  logic [DEPTH-1:0]      entry_valid;
`endif

  // Writes to the zero register are acknowledged but dropped here.
  assign b_ready = ~full;
  assign push    = b_valid & b_ready & (b_addr != REG_ZR);
  assign stall_o = (starve_cnt == SW'(MAX_STARVE)) & ~empty;

  wb_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_addr  (b_addr),
    .push_data  (b_data),
    .pop        (pop),
    .full       (full),
    .empty      (empty),
    .count      (fifo_count),
`ifdef WB_ARB_HAZARD_EN
    .entry_addr (entry_addr),
    .entry_valid(entry_valid),
`endif
    .head_addr  (head_addr),
    .head_data  (head_data)
  );

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    we3 = 1'b0;
    wa3 = '0;
    wd3 = '0;
    pop = 1'b0;
    if (!reset) begin
      if (stall_o || (!a_valid && !empty)) begin
        we3 = 1'b1;
        wa3 = head_addr;
        wd3 = head_data;
        pop = 1'b1;
      end else if (a_valid) begin
        we3 = 1'b1;
        wa3 = a_addr;
        wd3 = a_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (pop || empty) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SW'(MAX_STARVE)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

`ifdef WB_ARB_HAZARD_EN
  always_comb begin
    hazard_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && entry_addr[i] != REG_ZR &&
          (entry_addr[i] == ra1 || entry_addr[i] == ra2))
        hazard_o = 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a cycle model of the B FIFO and
// starvation counter predicts every write, stall and occupancy.
module tb_regfile_wb_arbiter;
  localparam int DEPTH      = 4;
  localparam int MAX_STARVE = 8;
  localparam int DW         = 64;

  typedef struct {
    logic [4:0]    addr;
    logic [DW-1:0] data;
  } ent_t;

  logic          clk, reset;
  logic          a_valid, b_valid, b_ready, stall_o, we3, hazard_o;
  logic [4:0]    a_addr, b_addr, wa3, ra1, ra2;
  logic [DW-1:0] a_data, b_data, wd3;
  logic [2:0]    fifo_count;

  ent_t mq[$];
  ent_t exp_q[$];
  int   starve;
  int   vectors, miscompares;
  int   stall_seen;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .MAX_STARVE(MAX_STARVE), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .a_valid    (a_valid),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .stall_o    (stall_o),
`ifdef WB_ARB_HAZARD_EN
    .ra1        (ra1),
    .ra2        (ra2),
    .hazard_o   (hazard_o),
`endif
    .we3        (we3),
    .wa3        (wa3),
    .wd3        (wd3),
    .fifo_count (fifo_count)
  );

`ifndef WB_ARB_HAZARD_EN
  assign hazard_o = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, predict, compare at negedge, then advance the model.
  task automatic step(input logic av, input logic [4:0] aa, input logic [DW-1:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [DW-1:0] bd);
    bit   exp_stall, gh, exp_haz;
    int   size_before;
    ent_t e;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    size_before = mq.size();
    exp_stall = (starve == MAX_STARVE) && (size_before > 0);
    gh = exp_stall || (!av && size_before > 0);
    if (gh) exp_q.push_back(mq[0]);
    else if (av) begin
      e.addr = aa; e.data = ad;
      exp_q.push_back(e);
    end
    exp_haz = 1'b0;
    foreach (mq[i])
      if (mq[i].addr != 5'd31 && (mq[i].addr == ra1 || mq[i].addr == ra2)) exp_haz = 1'b1;

    @(negedge clk);
    check("stall_o", stall_o, exp_stall);
    check("b_ready", b_ready, size_before < DEPTH);
    check("fifo_count", fifo_count, size_before);
    check("we3", we3, exp_q.size() != 0);
`ifdef WB_ARB_HAZARD_EN
    check("hazard_o", hazard_o, exp_haz);
`endif
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("wa3", wa3, e.addr);
      check("wd3", wd3, e.data);
    end else begin
      check("wa3_idle", wa3, 0);
      check("wd3_idle", wd3, 0);
    end
    if (stall_o) stall_seen++;

    if (gh) void'(mq.pop_front());
    if (bv && size_before < DEPTH && ba != 5'd31) begin
      e.addr = ba; e.data = bd;
      mq.push_back(e);
    end
    if (gh || size_before == 0) starve = 0;
    else if (starve < MAX_STARVE) starve++;

    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0; miscompares = 0; starve = 0; stall_seen = 0;
    reset = 1'b1;
    a_valid = 1'b1; a_addr = 5'd3; a_data = 64'h33;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    ra1 = 5'd0; ra2 = 5'd0;
    #3;
    check("rst_we3", we3, 0);
    check("rst_wa3", wa3, 0);
    check("rst_wd3", wd3, 0);
    check("rst_b_ready", b_ready, 1);
    check("rst_stall", stall_o, 0);
    check("rst_count", fifo_count, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    step(0, 0, 0, 0, 0, 0);                         // idle
    step(1, 5, 64'hAA, 0, 0, 0);                    // A write, empty FIFO
    step(0, 0, 0, 1, 7, 64'h77);                    // push B 7
    step(0, 0, 0, 0, 0, 0);                         // B 7 drains
    step(0, 0, 0, 0, 0, 0);                         // back to idle

    // One B entry starved by continuous A traffic until the stall fires.
    stall_seen = 0;
    step(1, 1, 64'h100, 1, 12, 64'hC0FFEE);
    for (int i = 0; i < 11; i++) step(1, 5'(2 + i % 20), 64'h200 + i, 0, 0, 0);
    check("stall_observed", stall_seen, 1);

    // Fill to DEPTH under A traffic; the 5th request waits for a pop.
    ra1 = 5'd9; ra2 = 5'd31;
    for (int i = 0; i < 5; i++) step(1, 5'd4, 64'h400 + i, 1, 5'(9 + i), 64'h900 + i);
    step(0, 0, 0, 1, 5'd13, 64'h904);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);

    // Zero-register B request is acknowledged but never written.
    step(0, 0, 0, 1, 5'd31, 64'hDEAD);
    step(0, 0, 0, 0, 0, 0);

    // Mixed random traffic.
    for (int i = 0; i < 300; i++) begin
      ra1 = 5'($urandom_range(0, 31));
      ra2 = 5'($urandom_range(0, 31));
      step(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), {$urandom, $urandom},
           ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), {$urandom, $urandom});
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0);

    // Reset asserted mid-fill: occupancy and writes drop immediately.
    for (int i = 0; i < 3; i++) step(1, 5'd6, 64'h600 + i, 1, 5'(20 + i), 64'h700 + i);
    check("prefill_count", fifo_count, 3);
    a_valid = 1'b1; b_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_count", fifo_count, 0);
    check("midrst_we3", we3, 0);
    mq.delete(); exp_q.delete(); starve = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, 0);
    step(1, 5'd8, 64'h88, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
